// File: rtl/adder_check_pkg.sv
// Shared types and defaults for the 4-bit adder response checker and its benches.
package adder_check_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_NUM_SAMPLES = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 cin;
    logic [DEF_WIDTH-1:0] s;
    logic                 cout;
  } sample_t;

endpackage

// File: rtl/adder_response_checker_if.sv
// Sample/control/result bundle between an adder test driver (master) and the checker (slave).
interface adder_response_checker_if
  import adder_check_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             sample_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;

  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_cin;
  logic [WIDTH-1:0] fail_s;
  logic             fail_cout;

  modport master (
    output start, sample_valid, a, b, cin, s, cout,
    input  busy, done, pass, sample_count, err_count,
           fail_valid, fail_a, fail_b, fail_cin, fail_s, fail_cout
  );

  modport slave (
    input  start, sample_valid, a, b, cin, s, cout,
    output busy, done, pass, sample_count, err_count,
           fail_valid, fail_a, fail_b, fail_cin, fail_s, fail_cout
  );
endinterface

// File: rtl/adder_golden_ref.sv
// Combinational reference adder: {exp_cout, exp_s} = a + b + cin at WIDTH+1 bits.
module adder_golden_ref
  import adder_check_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_exp_s,
  output logic             o_exp_cout
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign {o_exp_cout, o_exp_s} = w_sum;

endmodule

// File: rtl/adder_response_checker.sv
// Two-stage adder response checker: accepts samples, compares against the golden sum,
// counts samples/errors and captures the first failing sample.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_RUN   | accepting samples until NUM_SAMPLES taken
//   ST_DRAIN | last sample's comparison completes
//   ST_DONE  | results stable, pass/fail reported
module adder_response_checker
  import adder_check_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input logic                      clk,
  input logic                      rst_n,
  adder_response_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_busy;
  logic   w_done;
  logic   w_start;
  logic   w_accept;

  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic [WIDTH-1:0] r_s1_s;
  logic             r_s1_cout;
  logic [WIDTH-1:0] r_s1_exp_s;
  logic             r_s1_exp_cout;
  logic             r_s1_valid;

  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_fail_valid;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic             r_fail_cin;
  logic [WIDTH-1:0] r_fail_s;
  logic             r_fail_cout;

  logic [WIDTH-1:0] w_exp_s;
  logic             w_exp_cout;
  logic             w_mismatch;

  adder_golden_ref #(.WIDTH(WIDTH)) u_golden (
    .i_a        (bus.a),
    .i_b        (bus.b),
    .i_cin      (bus.cin),
    .o_exp_s    (w_exp_s),
    .o_exp_cout (w_exp_cout)
  );

  assign w_start  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept = (r_state == ST_RUN) && bus.sample_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_accept && (r_sample_count == LAST_CNT)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (w_start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Exact compare over all WIDTH+1 result bits, so carry-only faults are caught.
  assign w_mismatch = r_s1_valid &&
                      ({r_s1_cout, r_s1_s} != {r_s1_exp_cout, r_s1_exp_s});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a         <= '0;
      r_s1_b         <= '0;
      r_s1_cin       <= 1'b0;
      r_s1_s         <= '0;
      r_s1_cout      <= 1'b0;
      r_s1_exp_s     <= '0;
      r_s1_exp_cout  <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_fail_valid   <= 1'b0;
      r_fail_a       <= '0;
      r_fail_b       <= '0;
      r_fail_cin     <= 1'b0;
      r_fail_s       <= '0;
      r_fail_cout    <= 1'b0;
    end else if (w_start) begin
      r_s1_valid     <= 1'b0;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_fail_valid   <= 1'b0;
      r_fail_a       <= '0;
      r_fail_b       <= '0;
      r_fail_cin     <= 1'b0;
      r_fail_s       <= '0;
      r_fail_cout    <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a         <= bus.a;
        r_s1_b         <= bus.b;
        r_s1_cin       <= bus.cin;
        r_s1_s         <= bus.s;
        r_s1_cout      <= bus.cout;
        r_s1_exp_s     <= w_exp_s;
        r_s1_exp_cout  <= w_exp_cout;
        r_sample_count <= r_sample_count + 1'b1;
      end
      if (w_mismatch) begin
        if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_a     <= r_s1_a;
          r_fail_b     <= r_s1_b;
          r_fail_cin   <= r_s1_cin;
          r_fail_s     <= r_s1_s;
          r_fail_cout  <= r_s1_cout;
        end
      end
    end
  end

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.pass         = w_done && (r_err_count == '0);
  assign bus.sample_count = r_sample_count;
  assign bus.err_count    = r_err_count;
  assign bus.fail_valid   = r_fail_valid;
  assign bus.fail_a       = r_fail_a;
  assign bus.fail_b       = r_fail_b;
  assign bus.fail_cin     = r_fail_cin;
  assign bus.fail_s       = r_fail_s;
  assign bus.fail_cout    = r_fail_cout;

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker: clean, sum-fault, carry-fault, gap and reset runs.
module tb_adder_response_checker;
  import adder_check_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  adder_response_checker_if #(.WIDTH(4), .CNT_W(16)) bus ();

  adder_response_checker #(.WIDTH(4), .CNT_W(16), .NUM_SAMPLES(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sample i maps to a=i[8:5], b=i[4:1], cin=i[0]; index 511 is 15+15+1.
  function automatic sample_t mk(input int i);
    sample_t    r;
    logic [8:0] v;
    logic [4:0] sum;
    v     = i[8:0];
    r.a   = v[8:5];
    r.b   = v[4:1];
    r.cin = v[0];
    sum   = 5'(r.a) + 5'(r.b) + 5'(r.cin);
    r.s   = sum[3:0];
    r.cout = sum[4];
    return r;
  endfunction

  task automatic send(input sample_t smp, input logic vld);
    bus.sample_valid = vld;
    bus.a    = smp.a;
    bus.b    = smp.b;
    bus.cin  = smp.cin;
    bus.s    = smp.s;
    bus.cout = smp.cout;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_run(input int n, input int fault_at, input sample_t fault_smp, input bit gaps);
    sample_t smp;
    sample_t junk;
    for (int i = 0; i < n; i++) begin
      smp = mk(i);
      if (i == fault_at) smp = fault_smp;
      if (gaps && i == 50) bus.start = 1'b1;
      send(smp, 1'b1);
      bus.start = 1'b0;
      if (i == 0) chk("cnt_first", 32'(bus.sample_count), 32'd1);
      if (gaps && i == 50) chk("start_ignored_cnt", 32'(bus.sample_count), 32'd51);
      if (gaps) begin
        junk      = mk(i);
        junk.s    = ~junk.s;
        junk.cout = ~junk.cout;
        send(junk, 1'b0);
        if (i % 128 == 3) chk("gap_hold_cnt", 32'(bus.sample_count), 32'(i + 1));
      end
    end
  endtask

  task automatic expect_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_cnt"},  32'(bus.sample_count), 32'd0);
    chk({tag, "_err"},  32'(bus.err_count), 32'd0);
    chk({tag, "_fv"},   32'(bus.fail_valid), 32'd0);
    chk({tag, "_fail"}, 32'({bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_s, bus.fail_cout}), 32'd0);
  endtask

  sample_t f;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.s = '0; bus.cout = 1'b0;

    // reset held, then released with idle cycles
    idle(2);
    expect_zero_outputs("rst");
    rst_n = 1'b1;
    idle(5);
    expect_zero_outputs("idle");
    send(mk(5), 1'b1);
    chk("idle_valid_ignored", 32'(bus.sample_count), 32'd0);

    // exhaustive clean run
    do_start();
    chk("run_busy", 32'(bus.busy), 32'd1);
    do_run(512, -1, mk(0), 1'b0);
    chk("drain_busy", 32'(bus.busy), 32'd1);
    chk("drain_done", 32'(bus.done), 32'd0);
    chk("drain_cnt", 32'(bus.sample_count), 32'd512);
    idle(1);
    chk("clean_done", 32'(bus.done), 32'd1);
    chk("clean_busy", 32'(bus.busy), 32'd0);
    chk("clean_pass", 32'(bus.pass), 32'd1);
    chk("clean_cnt", 32'(bus.sample_count), 32'd512);
    chk("clean_err", 32'(bus.err_count), 32'd0);
    chk("clean_fv", 32'(bus.fail_valid), 32'd0);

    // sum fault at sample 100: 3+5+1 reported as 8
    f.a = 4'd3; f.b = 4'd5; f.cin = 1'b1; f.s = 4'd8; f.cout = 1'b0;
    do_start();
    chk("restart_done_drop", 32'(bus.done), 32'd0);
    chk("restart_cnt_clr", 32'(bus.sample_count), 32'd0);
    do_run(101, 100, f, 1'b0);
    chk("err_latency_before", 32'(bus.err_count), 32'd0);
    send(mk(101), 1'b1);
    chk("err_latency_after", 32'(bus.err_count), 32'd1);
    chk("fv_latency_after", 32'(bus.fail_valid), 32'd1);
    for (int i = 102; i < 512; i++) send(mk(i), 1'b1);
    idle(1);
    chk("sum_done", 32'(bus.done), 32'd1);
    chk("sum_err", 32'(bus.err_count), 32'd1);
    chk("sum_fv", 32'(bus.fail_valid), 32'd1);
    chk("sum_fail_a", 32'(bus.fail_a), 32'd3);
    chk("sum_fail_b", 32'(bus.fail_b), 32'd5);
    chk("sum_fail_cin", 32'(bus.fail_cin), 32'd1);
    chk("sum_fail_s", 32'(bus.fail_s), 32'd8);
    chk("sum_fail_cout", 32'(bus.fail_cout), 32'd0);
    chk("sum_pass", 32'(bus.pass), 32'd0);

    // carry-only fault on the final sample: 15+15+1 with cout dropped
    f.a = 4'd15; f.b = 4'd15; f.cin = 1'b1; f.s = 4'd15; f.cout = 1'b0;
    do_start();
    chk("carry_err_clr", 32'(bus.err_count), 32'd0);
    chk("carry_fv_clr", 32'(bus.fail_valid), 32'd0);
    do_run(512, 511, f, 1'b0);
    chk("carry_err_in_drain_pre", 32'(bus.err_count), 32'd0);
    idle(1);
    chk("carry_done", 32'(bus.done), 32'd1);
    chk("carry_err", 32'(bus.err_count), 32'd1);
    chk("carry_fail_cout", 32'(bus.fail_cout), 32'd0);
    chk("carry_fail_s", 32'(bus.fail_s), 32'd15);
    chk("carry_fail_a", 32'(bus.fail_a), 32'd15);
    chk("carry_pass", 32'(bus.pass), 32'd0);

    // gaps in sample_valid, start pulsed mid-run, valid while DONE
    do_start();
    do_run(512, -1, mk(0), 1'b1);
    chk("gap_done", 32'(bus.done), 32'd1);
    chk("gap_pass", 32'(bus.pass), 32'd1);
    chk("gap_cnt", 32'(bus.sample_count), 32'd512);
    for (int i = 0; i < 3; i++) send(mk(i), 1'b1);
    chk("done_valid_ignored", 32'(bus.sample_count), 32'd512);
    chk("done_hold", 32'(bus.done), 32'd1);

    // reset mid-run with one error logged, then a clean run
    f = mk(10);
    f.s = f.s ^ 4'b0001;
    do_start();
    do_run(200, 10, f, 1'b0);
    idle(1);
    chk("mid_cnt", 32'(bus.sample_count), 32'd200);
    chk("mid_err", 32'(bus.err_count), 32'd1);
    chk("mid_fv", 32'(bus.fail_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_zero_outputs("midrst");
    idle(1);
    rst_n = 1'b1;
    idle(1);
    do_start();
    do_run(512, -1, mk(0), 1'b0);
    idle(1);
    chk("final_done", 32'(bus.done), 32'd1);
    chk("final_pass", 32'(bus.pass), 32'd1);
    chk("final_cnt", 32'(bus.sample_count), 32'd512);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
